// File: rtl/encoder_16to4_seq_if.sv
// Request/select bus for the sequential 16:4 encoder.
interface encoder_16to4_seq_if;
  localparam int unsigned REQ_W  = 16;
  localparam int unsigned CODE_W = 4;

  logic [REQ_W-1:0]  req_in;
  logic              load;
  logic              ready;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              busy;
  logic              done;
  logic              zero;

  // Request producer / code consumer side
  modport master (
    output req_in, load, ready,
    input  code, valid, busy, done, zero
  );

  // Encoder side
  modport slave (
    input  req_in, load, ready,
    output code, valid, busy, done, zero
  );
endinterface

// File: rtl/encoder_16to4_seq.sv
// Sequential 16:4 encoder: captures a request vector and emits the index of
// each set bit, one per accepted handshake, in fixed priority order.
module encoder_16to4_seq #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  encoder_16to4_seq_if.slave   bus
);
  localparam int unsigned REQ_W  = 16;
  localparam int unsigned CODE_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t              state, state_d;
  logic [REQ_W-1:0]    pending, pending_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                zero_q, zero_d;
  logic [CODE_W-1:0]   sel;

  // Index of the highest-priority set bit; later loop hits override earlier ones
  function automatic logic [CODE_W-1:0] prio(input logic [REQ_W-1:0] p);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(REQ_W); i++) begin
      if (LOW_FIRST) begin
        if (p[int'(REQ_W) - 1 - i]) idx = CODE_W'(int'(REQ_W) - 1 - i);
      end else begin
        if (p[i]) idx = CODE_W'(i);
      end
    end
    return idx;
  endfunction

  // State, pending vector and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state   <= state_d;
      pending <= pending_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic; outputs are precomputed from next state so code/valid
  // never see a combinational path from ready, load or req_in
  always_comb begin
    state_d   = state;
    pending_d = pending;
    done_d    = 1'b0;
    zero_d    = 1'b0;
    sel       = prio(pending);
    case (state)
      IDLE: begin
        if (bus.load) begin
          if (bus.req_in != '0) begin
            pending_d = bus.req_in;
            state_d   = EMIT;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus.ready) begin
          pending_d = pending & ~(REQ_W'(1) << sel);
          if (pending_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
    valid_d = (state_d == EMIT);
    code_d  = valid_d ? prio(pending_d) : '0;
  end

  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.busy  = valid_q;
  assign bus.done  = done_q;
  assign bus.zero  = zero_q;
endmodule
